// File: rtl/gb_instr_sequencer.sv
// gb_instr_sequencer: turns a raw program byte stream into one-cycle
// instruction/data/valid issue beats for the gbprocessor core.
// Bytes are buffered in a DEPTH-entry FIFO. A load-immediate opcode is
// paired with the byte that follows it. Every other opcode issues alone
// with data=00.
// Optional build macro GBSEQ_ILLEGAL_DROP_EN: opcodes 00-3F (other than the
// load-immediates) and C0-FF are popped and discarded instead of issued,
// and the sticky illegal_seen output reports that a discard has happened.
module gb_instr_sequencer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  input  logic             proc_stall,
  output logic [7:0]       instruction,
  output logic [7:0]       data,
  output logic             valid,
  output logic             busy,
`ifdef GBSEQ_ILLEGAL_DROP_EN
  output logic             illegal_seen,
`endif
  output logic [CNT_W-1:0] issued_count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {S_OPCODE, S_OPERAND} state_t;

  // FIFO storage. The pointers carry one extra wrap bit so that full and
  // empty can be told apart.
  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic        empty, full, push, pop;
  logic [7:0]  head;

  state_t      state_q, state_d;
  logic [7:0]  opc_q, opc_d;
  logic [7:0]  instr_d, data_d;
  logic        valid_d;
`ifdef GBSEQ_ILLEGAL_DROP_EN
  logic        ill_d;
`endif

  function automatic logic is_ldi(input logic [7:0] b);
    case (b)
      8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h3E: is_ldi = 1'b1;
      default:                                         is_ldi = 1'b0;
    endcase
  endfunction

`ifdef GBSEQ_ILLEGAL_DROP_EN
  function automatic logic is_illegal(input logic [7:0] b);
    is_illegal = ((b[7:6] == 2'b00) && !is_ldi(b)) || (b[7:6] == 2'b11);
  endfunction
`endif

  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  // There is no bypass path: a full FIFO refuses a push even when it pops in the same cycle.
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign pop      = !empty && !proc_stall;
  assign head     = mem[rptr[AW-1:0]];
  assign busy     = !empty || (state_q == S_OPERAND);

  // FIFO data write. The entries need no reset because the pointers gate every read.
  always_ff @(posedge clock) begin
    if (!reset && !flush && push) mem[wptr[AW-1:0]] <= in_byte;
  end

  // FIFO pointers. Reset and flush both empty the buffer.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // FSM state register. A flush abandons any half-assembled instruction.
  always_ff @(posedge clock) begin
    if (reset || flush) state_q <= S_OPCODE;
    else                state_q <= state_d;
  end

  // Next state. Only a pop can move the FSM. The operand byte is never decoded.
  always_comb begin
    state_d = state_q;
    if (pop) begin
      case (state_q)
        S_OPCODE:  if (is_ldi(head)) state_d = S_OPERAND;
        S_OPERAND: state_d = S_OPCODE;
        default:   state_d = S_OPCODE;
      endcase
    end
  end

  // Next output values. instruction and data hold while nothing issues.
  always_comb begin
    instr_d = instruction;
    data_d  = data;
    valid_d = 1'b0;
    opc_d   = opc_q;
`ifdef GBSEQ_ILLEGAL_DROP_EN
    ill_d   = 1'b0;
`endif
    if (pop) begin
      case (state_q)
        S_OPCODE: begin
          if (is_ldi(head)) begin
            opc_d = head;
`ifdef GBSEQ_ILLEGAL_DROP_EN
          end else if (is_illegal(head)) begin
            ill_d = 1'b1;
`endif
          end else begin
            instr_d = head;
            data_d  = 8'h00;
            valid_d = 1'b1;
          end
        end
        S_OPERAND: begin
          instr_d = opc_q;
          data_d  = head;
          valid_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Registered outputs. A flush drops valid and the latched opcode but keeps the counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      instruction  <= 8'h00;
      data         <= 8'h00;
      valid        <= 1'b0;
      opc_q        <= 8'h00;
      issued_count <= '0;
    end else if (flush) begin
      valid        <= 1'b0;
      opc_q        <= 8'h00;
    end else begin
      instruction  <= instr_d;
      data         <= data_d;
      valid        <= valid_d;
      opc_q        <= opc_d;
      issued_count <= issued_count + CNT_W'(valid_d);
    end
  end

`ifdef GBSEQ_ILLEGAL_DROP_EN
  // Sticky discard flag. Only reset clears it; a flush leaves it set.
  always_ff @(posedge clock) begin
    if (reset)              illegal_seen <= 1'b0;
    else if (!flush && ill_d) illegal_seen <= 1'b1;
  end
`endif

endmodule

// File: doc/gb_instr_sequencer.md
Name: gb_instr_sequencer

Overview:
- Converts a raw program byte stream into one-cycle instruction/data/valid issue beats for the gbprocessor core.
- Buffers incoming bytes in a FIFO.
- Pairs each load-immediate opcode (06,0E,16,1E,26,2E,3E) with its following operand byte.
- Issues every other opcode as a single-byte beat.
- Sits between the program source (testbench or ROM reader) and the processor's instruction/data/valid inputs.

Parameters:
- DEPTH, 8, byte FIFO entries; power of two, >=2
- CNT_W, 16, width of issued_count

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- in_byte  in  8  program byte (opcode or operand)
- in_valid  in  1  in_byte is presented
- in_ready  out  1  FIFO can accept; transfer when in_valid&in_ready at an edge
- flush  in  1  synchronous clear of FIFO and FSM; counters kept
- proc_stall  in  1  inhibits issue while high
- instruction  out  8  to processor instruction input
- data  out  8  to processor data input
- valid  out  1  one-cycle issue strobe to processor
- busy  out  1  FIFO non-empty or state==S_OPERAND
- issued_count  out  CNT_W  number of valid beats issued; wraps modulo 2^CNT_W

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: FIFO empty; state S_OPCODE; instruction=00, data=00, valid=0, issued_count=0, in_ready=1 (on the cycle after reset), busy=0.
- Priority at each edge: reset > flush > normal operation.
- FIFO:
  - in_ready = !full. There is no bypass: a push on a full FIFO is refused even when a pop occurs in the same cycle.
  - Push and pop in the same edge are allowed when neither full nor empty.
  - Read and write pointers wrap modulo DEPTH.
- Outputs: all outputs are registered. valid is high for exactly one cycle per issued instruction. instruction and data hold their last values while valid=0.
- FSM, S_OPCODE:
  - Pops only when FIFO non-empty and proc_stall=0.
  - Popped byte is a load-immediate opcode: latch it in the opcode register, go to S_OPERAND, valid=0.
  - Otherwise: instruction<=byte, data<=00, valid<=1, issued_count++, stay in S_OPCODE.
- FSM, S_OPERAND:
  - Pops only when FIFO non-empty and proc_stall=0.
  - On pop: instruction<=latched opcode, data<=byte, valid<=1, issued_count++, go to S_OPCODE.
  - The operand byte is never decoded, even if it equals an opcode value.
- No pop (empty or stalled): valid<=0, state unchanged.
- Latency:
  - Byte pushed at edge k into an empty FIFO can be popped at edge k+1.
  - A single-byte instruction is valid during the cycle after edge k+1.
  - Back-to-back single-byte instructions issue every cycle.
  - A two-byte instruction issues one cycle after its operand is popped.
- proc_stall=1: no pop and no issue. A valid beat already registered still completes its single cycle; stall does not extend it.
- flush=1: FIFO emptied, state->S_OPCODE, latched opcode cleared, valid<=0. A byte presented in the flush cycle is dropped, and in_ready may still read 1 that cycle. issued_count is unchanged.
- Reset mid-instruction (including in S_OPERAND): a pending opcode is discarded and never issued.
- issued_count wraps from 2^CNT_W-1 to 0 with no flag.

Optional Feature:
- Macro: GBSEQ_ILLEGAL_DROP_EN.
- Defined:
  - Opcodes 00-3F other than the seven load-immediate codes, and C0-FF, are popped and discarded: no valid beat and no issued_count increment.
  - Extra output port illegal_seen (1 bit, sticky) sets on each discard and is cleared by reset only, not by flush.
- Undefined: these opcodes issue as single-byte beats (data=00), counted; illegal_seen port does not exist.

Test Plan:
- Reset, then push 80,88,90 one per cycle, no stall -> three consecutive valid beats: instruction 80,88,90, data 00 each; issued_count=3.
- Push 3E,5A,47 -> beat1 instruction=3E, data=5A; beat2 instruction=47, data=00; no valid between the opcode pop and the operand pop.
- Push 06 then 06 -> one beat, instruction=06, data=06; issued_count=1; state back to S_OPCODE.
- DEPTH=8, proc_stall=1, push 10 bytes -> in_ready falls after 8 accepts; deassert stall -> 8 bytes issued in order, then the remaining 2 are accepted.
- Push 0E, flush in the next cycle, then push 80 -> no beat for 0E; single beat instruction=80; issued_count increments by 1 only. Repeat with reset instead of flush: issued_count=1 after 80.
- Push 00, C7, 80 -> with GBSEQ_ILLEGAL_DROP_EN: one beat (80), illegal_seen=1. Without the macro: three beats (00, C7, 80), issued_count=3.
